// File: rtl/uart_arbiter.sv
// Purpose: shares one byte-wide UART wrapper between requesters A and B (round-robin TX, owner-routed RX).
// Latency: REQ seen in IDLE cycle N gives U_WR in cycle N+1; DONE pulses one cycle after U_RDY returns high.
// Backpressure: TX waits in IDLE while U_RDY=0; RX holds the byte until the owner's ACK reaches U_ACK.
//
// Ports:
//   CLK, RESET                   clock, asynchronous active-high reset
//   A_REQ/A_DATA/A_DONE          requester A transmit handshake (level REQ, one-cycle DONE)
//   B_REQ/B_DATA/B_DONE          requester B transmit handshake
//   GRANT, BUSY                  current/last transmit owner (0=A, 1=B), FSM not idle
//   RX_OWNER, RX_DATA            receive destination select, received byte
//   A_RDA/A_ACK, B_RDA/B_ACK     per-requester receive pending / consume
//   U_IN/U_WR/U_RDY              UART transmit side
//   U_OUT/U_RDA/U_ACK            UART receive side
module uart_arbiter #(
    parameter int GUARD_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       A_REQ,
    input  logic [7:0] A_DATA,
    output logic       A_DONE,
    input  logic       B_REQ,
    input  logic [7:0] B_DATA,
    output logic       B_DONE,
    output logic       GRANT,
    output logic       BUSY,
    input  logic       RX_OWNER,
    output logic [7:0] RX_DATA,
    output logic       A_RDA,
    input  logic       A_ACK,
    output logic       B_RDA,
    input  logic       B_ACK,
    output logic [7:0] U_IN,
    output logic       U_WR,
    input  logic       U_RDY,
    input  logic [7:0] U_OUT,
    input  logic       U_RDA,
    output logic       U_ACK
);

    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        START,
        DRAIN,
        COMPLETE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [GW-1:0]   guard_cnt;
    logic [GW-1:0]   guard_nxt;
    logic            last_b;      // last-served requester, 1 = B
    logic            pick_b;

    // ------------------------------------------------------------------
    // Transmit FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        guard_nxt = guard_cnt;
        // On a tie the requester that was not served last wins.
        pick_b    = B_REQ & (~A_REQ | ~last_b);
        case (state)
            IDLE: begin
                if (U_RDY && (A_REQ || B_REQ)) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = START;
                guard_nxt = GW'(GUARD_CYCLES - 1);
            end
            START: begin
                // A UART that never drops RDY for a byte is treated as having
                // accepted it once the guard window runs out.
                if (!U_RDY || guard_cnt == '0) begin
                    state_nxt = DRAIN;
                end else begin
                    guard_nxt = guard_cnt - 1'b1;
                end
            end
            DRAIN: begin
                if (U_RDY) begin
                    state_nxt = COMPLETE;
                end
            end
            COMPLETE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Transmit FSM: state and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            guard_cnt <= '0;
            last_b    <= 1'b1;
            U_IN      <= 8'h00;
            U_WR      <= 1'b0;
            GRANT     <= 1'b0;
            A_DONE    <= 1'b0;
            B_DONE    <= 1'b0;
        end else begin
            state     <= state_nxt;
            guard_cnt <= guard_nxt;
            U_WR      <= (state_nxt == ISSUE);
            A_DONE    <= (state_nxt == COMPLETE) && !GRANT;
            B_DONE    <= (state_nxt == COMPLETE) && GRANT;
            // Byte and owner are latched only at the grant; later REQ/DATA
            // activity cannot disturb a transfer in flight.
            if (state == IDLE && state_nxt == ISSUE) begin
                U_IN  <= pick_b ? B_DATA : A_DATA;
                GRANT <= pick_b;
            end
            if (state == COMPLETE) begin
                last_b <= GRANT;
            end
        end
    end

    assign BUSY = (state != IDLE);

    // ------------------------------------------------------------------
    // Receive routing
    // ------------------------------------------------------------------
    logic rda_prev;
    logic rx_owner_q;
    logic rx_arrive;
    logic rx_owner_eff;

    assign rx_arrive = U_RDA & ~rda_prev;
    // In the arrival cycle the owner register has not loaded yet, so route
    // from RX_OWNER directly; afterwards the latched owner pins the byte.
    assign rx_owner_eff = rx_arrive ? RX_OWNER : rx_owner_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rda_prev   <= 1'b0;
            rx_owner_q <= 1'b0;
        end else begin
            rda_prev <= U_RDA;
            if (rx_arrive) begin
                rx_owner_q <= RX_OWNER;
            end
        end
    end

    assign RX_DATA = U_OUT;
    assign A_RDA   = U_RDA & ~rx_owner_eff;
    assign B_RDA   = U_RDA & rx_owner_eff;
    assign U_ACK   = (A_ACK & ~rx_owner_eff) | (B_ACK & rx_owner_eff);

endmodule

// File: tb/tb_uart_arbiter.sv
// Purpose: self-checking bench for uart_arbiter with a UART behavioural model and a timeline reference model.
// Latency: checks every cycle at the falling edge; directed literals pin the WR/DONE timing.
// Backpressure: the UART model drops RDY for a programmable window after each WR, or never.
module tb_uart_arbiter;

    localparam int G = 4;

    logic       CLK;
    logic       RESET;
    logic       A_REQ, B_REQ;
    logic [7:0] A_DATA, B_DATA;
    logic       A_DONE, B_DONE;
    logic       GRANT, BUSY;
    logic       RX_OWNER;
    logic [7:0] RX_DATA;
    logic       A_RDA, A_ACK, B_RDA, B_ACK;
    logic [7:0] U_IN;
    logic       U_WR;
    logic       U_RDY;
    logic [7:0] U_OUT;
    logic       U_RDA;
    logic       U_ACK;

    uart_arbiter #(.GUARD_CYCLES(G)) dut (
        .CLK(CLK), .RESET(RESET),
        .A_REQ(A_REQ), .A_DATA(A_DATA), .A_DONE(A_DONE),
        .B_REQ(B_REQ), .B_DATA(B_DATA), .B_DONE(B_DONE),
        .GRANT(GRANT), .BUSY(BUSY),
        .RX_OWNER(RX_OWNER), .RX_DATA(RX_DATA),
        .A_RDA(A_RDA), .A_ACK(A_ACK), .B_RDA(B_RDA), .B_ACK(B_ACK),
        .U_IN(U_IN), .U_WR(U_WR), .U_RDY(U_RDY),
        .U_OUT(U_OUT), .U_RDA(U_RDA), .U_ACK(U_ACK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int nvec = 0;
    int nmis = 0;
    int cyc  = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // UART behavioural model: RDY low for [WR+drop_dly, WR+drop_dly+hold)
    // ------------------------------------------------------------------
    int low_at = -1;
    int high_at = -1;
    int drop_dly = 1;
    int hold = 10;
    bit never_drop = 0;
    bit force_low = 0;

    always @(negedge CLK) begin
        if (RESET) begin
            low_at  = -1;
            high_at = -1;
        end else if (U_WR && !never_drop) begin
            low_at  = cyc + drop_dly;
            high_at = low_at + hold;
        end
    end

    always @(posedge CLK) begin
        #2;
        U_RDY = !(force_low || (cyc >= low_at && cyc < high_at));
    end

    // ------------------------------------------------------------------
    // Reference model: transaction timeline (grant, WR, accept, done)
    // ------------------------------------------------------------------
    bit   m_active = 0;
    bit   m_grant = 0;
    bit   m_last = 1;
    logic [7:0] m_byte = 8'h00;
    int   m_wr = -1, m_drain = -1, m_done = -1;
    bit   m_rx_owner = 0, m_rda_prev = 0, e_owner;

    logic [7:0] wr_dat[$];
    bit         wr_gnt[$];
    int         wr_cyc[$];
    int a_done_n = 0, b_done_n = 0;
    int a_done_cyc = -100, b_done_cyc = -100;

    always @(negedge CLK) begin
        if (RESET) begin
            m_active = 0; m_grant = 0; m_last = 1; m_byte = 8'h00;
            m_wr = -1; m_drain = -1; m_done = -1;
            m_rx_owner = 0; m_rda_prev = 0;
            chk("rst_u_wr", U_WR, 0);
            chk("rst_u_in", U_IN, 0);
            chk("rst_grant", GRANT, 0);
            chk("rst_busy", BUSY, 0);
            chk("rst_done", {A_DONE, B_DONE}, 0);
        end else begin
            e_owner = (U_RDA && !m_rda_prev) ? RX_OWNER : m_rx_owner;
            chk("u_wr", U_WR, m_active && cyc == m_wr);
            chk("u_in", U_IN, m_byte);
            chk("grant", GRANT, m_grant);
            chk("busy", BUSY, m_active);
            chk("a_done", A_DONE, m_active && cyc == m_done && !m_grant);
            chk("b_done", B_DONE, m_active && cyc == m_done && m_grant);
            chk("a_rda", A_RDA, U_RDA && !e_owner);
            chk("b_rda", B_RDA, U_RDA && e_owner);
            chk("u_ack", U_ACK, e_owner ? B_ACK : A_ACK);
            chk("rx_data", RX_DATA, U_OUT);

            if (U_WR) begin
                wr_dat.push_back(U_IN);
                wr_gnt.push_back(GRANT);
                wr_cyc.push_back(cyc);
            end
            if (A_DONE) begin a_done_n++; a_done_cyc = cyc; end
            if (B_DONE) begin b_done_n++; b_done_cyc = cyc; end

            m_rx_owner = e_owner;
            m_rda_prev = U_RDA;
            if (m_active) begin
                if (cyc == m_done) begin
                    m_active = 0;
                    m_last   = m_grant;
                end else begin
                    // Accepted on the first RDY-low cycle inside the guard
                    // window after WR, or when the window closes.
                    if (m_drain < 0 && cyc > m_wr && cyc <= m_wr + G &&
                        (!U_RDY || cyc == m_wr + G))
                        m_drain = cyc + 1;
                    if (m_drain >= 0 && cyc >= m_drain && m_done < 0 && U_RDY)
                        m_done = cyc + 1;
                end
            end else if (U_RDY && (A_REQ || B_REQ)) begin
                m_grant  = (A_REQ && B_REQ) ? !m_last : B_REQ;
                m_byte   = m_grant ? B_DATA : A_DATA;
                m_active = 1;
                m_wr     = cyc + 1;
                m_drain  = -1;
                m_done   = -1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_dones(input int target, input int budget, input string nm);
        int n;
        n = 0;
        while ((a_done_n + b_done_n) < target && n < budget) begin
            tick();
            n++;
        end
        chk(nm, a_done_n + b_done_n, target);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        A_REQ = 0; B_REQ = 0;
        repeat (2) tick();
        RESET = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [7:0] exp_dat[4];
    bit         exp_gnt[4];

    initial begin
        int c0, n0, nw0, nb0, r;
        RESET = 1; A_REQ = 0; B_REQ = 0; A_DATA = 0; B_DATA = 0;
        RX_OWNER = 0; A_ACK = 0; B_ACK = 0; U_OUT = 0; U_RDA = 0; U_RDY = 1;
        do_reset();
        tick();
        chk("init_busy", BUSY, 0);
        chk("init_grant", GRANT, 0);

        // Test 1: single A byte, RDY drops 1 cycle after WR for 10 cycles
        never_drop = 0; force_low = 0; drop_dly = 1; hold = 10;
        c0 = cyc; n0 = a_done_n + b_done_n; nw0 = wr_cyc.size();
        A_DATA = 8'h41; A_REQ = 1;
        wait_dones(n0 + 1, 60, "t1_wait_done");
        A_REQ = 0;
        chk("t1_wr_count", wr_cyc.size() - nw0, 1);
        if (wr_cyc.size() > nw0) begin
            chk("t1_wr_latency", wr_cyc[nw0] - c0, 1);
            chk("t1_u_in", wr_dat[nw0], 8'h41);
        end
        chk("t1_done_cycle", a_done_cyc - c0, 13);
        chk("t1_b_done", b_done_n, 0);

        // Test 2: both held continuously -> strict alternation starting with A
        do_reset();
        drop_dly = 1; hold = 3;
        n0 = a_done_n + b_done_n; nw0 = wr_cyc.size(); nb0 = b_done_n;
        A_DATA = 8'h11; B_DATA = 8'h22; A_REQ = 1; B_REQ = 1;
        wait_dones(n0 + 4, 200, "t2_wait_done");
        A_REQ = 0; B_REQ = 0;
        exp_dat = '{8'h11, 8'h22, 8'h11, 8'h22};
        exp_gnt = '{1'b0, 1'b1, 1'b0, 1'b1};
        chk("t2_wr_count", wr_cyc.size() - nw0, 4);
        for (int i = 0; i < 4; i++) begin
            if (wr_cyc.size() > nw0 + i) begin
                chk("t2_u_in_seq", wr_dat[nw0 + i], exp_dat[i]);
                chk("t2_grant_seq", wr_gnt[nw0 + i], exp_gnt[i]);
            end
        end
        chk("t2_b_dones", b_done_n - nb0, 2);

        // Test 3: UART never drops RDY -> guard expiry
        tick();
        never_drop = 1;
        c0 = cyc; n0 = a_done_n + b_done_n;
        A_DATA = 8'h7E; A_REQ = 1;
        wait_dones(n0 + 1, 40, "t3_wait_done");
        A_REQ = 0;
        chk("t3_done_cycle", a_done_cyc - c0, 7);
        never_drop = 0;

        // Test 4: RDY low in IDLE holds off the grant
        tick();
        force_low = 1; drop_dly = 1; hold = 2;
        nw0 = wr_cyc.size(); n0 = a_done_n + b_done_n;
        A_DATA = 8'h3C; A_REQ = 1;
        repeat (6) tick();
        chk("t4_no_wr", wr_cyc.size() - nw0, 0);
        chk("t4_idle", BUSY, 0);
        force_low = 0; r = cyc;
        wait_dones(n0 + 1, 40, "t4_wait_done");
        A_REQ = 0;
        if (wr_cyc.size() > nw0) chk("t4_wr_after_rdy", wr_cyc[nw0] - r, 1);

        // Test 5: receive routing
        tick();
        RX_OWNER = 1; U_OUT = 8'h5A; U_RDA = 1; A_ACK = 1;
        #3;
        chk("t5_b_rda", B_RDA, 1);
        chk("t5_a_rda", A_RDA, 0);
        chk("t5_rx_data", RX_DATA, 8'h5A);
        chk("t5_nonowner_ack", U_ACK, 0);
        tick();
        RX_OWNER = 0; A_ACK = 0; B_ACK = 1;
        #3;
        chk("t5_b_rda_held", B_RDA, 1);
        chk("t5_a_rda_held", A_RDA, 0);
        chk("t5_owner_ack", U_ACK, 1);
        tick();
        U_RDA = 0; B_ACK = 0;
        tick();
        U_RDA = 1; U_OUT = 8'hA5; RX_OWNER = 0;
        #3;
        chk("t5_a_rda", A_RDA, 1);
        chk("t5_b_rda_off", B_RDA, 0);
        tick();
        U_RDA = 0;

        // Test 6: reset during DRAIN, then A served first
        tick();
        drop_dly = 1; hold = 30;
        nb0 = b_done_n;
        B_DATA = 8'hC3; B_REQ = 1;
        repeat (5) tick();
        chk("t6_pre_busy", BUSY, 1);
        chk("t6_pre_grant", GRANT, 1);
        chk("t6_pre_u_in", U_IN, 8'hC3);
        #2;
        RESET = 1;
        #1;
        chk("t6_async_u_in", U_IN, 0);
        chk("t6_async_grant", GRANT, 0);
        chk("t6_async_busy", BUSY, 0);
        chk("t6_async_wr_done", {U_WR, A_DONE, B_DONE}, 0);
        B_REQ = 0;
        repeat (2) tick();
        RESET = 0;
        n0 = a_done_n + b_done_n; nw0 = wr_cyc.size();
        A_DATA = 8'h99; B_DATA = 8'h66; A_REQ = 1; B_REQ = 1;
        drop_dly = 1; hold = 4;
        wait_dones(n0 + 1, 60, "t6_wait_done");
        A_REQ = 0; B_REQ = 0;
        if (wr_cyc.size() > nw0) begin
            chk("t6_first_grant", wr_gnt[nw0], 0);
            chk("t6_first_byte", wr_dat[nw0], 8'h99);
        end
        chk("t6_no_b_done", b_done_n - nb0, 0);

        // Random phase: both agents, random UART timing, random RX traffic
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (A_REQ) begin
                if (a_done_cyc == cyc - 1) A_REQ = 0;
            end else if ($urandom_range(0, 3) == 0) begin
                A_REQ = 1; A_DATA = 8'($urandom);
            end
            if (B_REQ) begin
                if (b_done_cyc == cyc - 1) B_REQ = 0;
            end else if ($urandom_range(0, 3) == 0) begin
                B_REQ = 1; B_DATA = 8'($urandom);
            end
            force_low = ($urandom_range(0, 7) == 0);
            drop_dly  = $urandom_range(1, 6);
            hold      = $urandom_range(0, 8);
            if (U_RDA) begin
                if ($urandom_range(0, 2) == 0) U_RDA = 0;
            end else if ($urandom_range(0, 2) == 0) begin
                U_RDA = 1; U_OUT = 8'($urandom);
            end
            RX_OWNER = 1'($urandom);
            A_ACK    = 1'($urandom);
            B_ACK    = 1'($urandom);
        end
        A_REQ = 0; B_REQ = 0; force_low = 0; U_RDA = 0; A_ACK = 0; B_ACK = 0;
        repeat (40) tick();
        chk("end_idle", BUSY, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
